// File: rtl/mips16_pkg.sv
// Shared definitions for the data-memory arbitration slice: default widths,
// port identifiers and a counter-width helper.
package mips16_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int ADDR_W_DEF   = 16;
   localparam int MAX_WAIT_DEF = 4;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DMA = 1'b1
   } port_e;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// DMA starvation guard: counts consecutive denied DMA cycles and raises
// dma_force once the DMA port has waited MAX_WAIT cycles.
module arb_starve_ctr
   import mips16_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic dma_req,
   input  logic dma_gnt,
   output logic dma_force
);

   localparam int               CNT_W    = cnt_width(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAX_WAIT);

   // Remaining denial budget; it holds MAX_WAIT minus the wait count, so
   // reaching zero is the same as the wait count sitting at MAX_WAIT.
   logic [CNT_W-1:0] budget_d, budget_q;

   always_comb begin
      budget_d = budget_q;
      if (!dma_req || dma_gnt) begin
         budget_d = CNT_LOAD;
      end else if (budget_q != '0) begin
         budget_d = budget_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         budget_q <= CNT_LOAD;
      end else begin
         budget_q <= budget_d;
      end
   end

   assign dma_force = (budget_q == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU, DMA) arbiter in front of a single-port data memory with
// CPU priority, bounded DMA starvation and one-cycle read return.
module dmem_arbiter
   import mips16_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,

   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);

   logic  dma_force;
   logic  pend_vld_d, pend_vld_q;
   port_e pend_port_d, pend_port_q;

   arb_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk       (clk),
      .reset     (reset),
      .dma_req   (dma_req),
      .dma_gnt   (dma_gnt),
      .dma_force (dma_force)
   );

   // Grants are gated by reset so they drop immediately when reset asserts,
   // independent of the clock.
   always_comb begin
      dma_gnt   = reset & dma_req & (~cpu_req | dma_force);
      cpu_gnt   = reset & cpu_req & ~dma_gnt;
      cpu_stall = reset & cpu_req & ~cpu_gnt;
   end

   always_comb begin
      mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
      mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
      mem_we    = (cpu_gnt & cpu_we)  | (dma_gnt & dma_we);
      mem_re    = (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
   end

   // A granted read leaves a tag that steers next cycle's mem_rdata.
   always_comb begin
      pend_vld_d  = mem_re;
      pend_port_d = pend_port_q;
      if (mem_re) begin
         pend_port_d = dma_gnt ? PORT_DMA : PORT_CPU;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_vld_q  <= 1'b0;
         pend_port_q <= PORT_CPU;
      end else begin
         pend_vld_q  <= pend_vld_d;
         pend_port_q <= pend_port_d;
      end
   end

   always_comb begin
      cpu_rvalid = pend_vld_q & (pend_port_q == PORT_CPU);
      dma_rvalid = pend_vld_q & (pend_port_q == PORT_DMA);
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
      dma_rdata  = dma_rvalid ? mem_rdata : '0;
   end

endmodule
